// File: rtl/zwracanie_digitow_pkg.sv
// Shared widths, limits and FSM encoding for the rpm-to-BCD display converter.
package zwracanie_digitow_pkg;

    localparam int RPM_W = 7;
    localparam int BCD_W = 8;

    localparam logic [RPM_W-1:0] MAX_RPM = 7'd99;
    localparam logic [BCD_W-1:0] SAT_BCD = 8'h99;

    localparam int SHIFT_CYCLES = 7;
    localparam int CNT_W        = $clog2(SHIFT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SHIFT_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/zwracanie_digitow_bcd_add3.sv
// Double-dabble nibble correction: values of 5 or more get +3 before the next shift.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/zwracanie_digitow_bcd.sv
// Free-running sequential binary-to-BCD converter for the rpm display.
// Each 9-cycle frame is LOAD, 7x SHIFT, WRITE; only WRITE touches the output.
module zwracanie_digitow_bcd
    import zwracanie_digitow_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RPM_W-1:0] rpm,
    output logic [BCD_W-1:0] rpm_w_BCD
);

    state_t           r_state;
    logic [RPM_W-1:0] r_bin;
    logic [BCD_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [BCD_W-1:0] r_bcd;

    logic [RPM_W-1:0] w_rpm_sat;
    logic [BCD_W-1:0] w_acc_adj;

    // Saturating at 99 keeps the tens nibble a valid digit and the accumulator from overflowing.
    assign w_rpm_sat = (rpm > MAX_RPM) ? MAX_RPM : rpm;

    bcd_add3 u_add3_tens (
        .i_nib (r_acc[7:4]),
        .o_nib (w_acc_adj[7:4])
    );

    bcd_add3 u_add3_units (
        .i_nib (r_acc[3:0]),
        .o_nib (w_acc_adj[3:0])
    );

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_bin   <= w_rpm_sat;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    {r_acc, r_bin} <= {w_acc_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_SHIFT) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_bcd   <= r_acc;
                    r_state <= LOAD;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign rpm_w_BCD = r_bcd;

endmodule

// File: tb/tb_zwracanie_digitow_bcd.sv
// Self-checking bench: frame-timed behavioural model plus literal pins for the rpm BCD converter.
module tb_zwracanie_digitow_bcd;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] rpm;
    logic [7:0] rpm_w_BCD;

    int n_checks = 0;
    int n_errors = 0;

    zwracanie_digitow_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rpm       (rpm),
        .rpm_w_BCD (rpm_w_BCD)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        int s;
        s = (v > 99) ? 99 : v;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    // Reference model: rpm is sampled on frame edge 0 and displayed on frame edge 8.
    int         edge_cnt  = 0;
    int         frame_rpm = 0;
    logic [7:0] exp_out   = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt = 0;
            exp_out  = 8'h00;
        end else begin
            if (edge_cnt % 9 == 0) frame_rpm = int'(rpm);
            if (edge_cnt % 9 == 8) exp_out = to_bcd(frame_rpm);
            edge_cnt++;
        end
    end

    // Per-cycle comparison, digit validity and update spacing.
    logic       mon_en    = 1'b0;
    logic       have_prev = 1'b0;
    logic [7:0] prev_out  = 8'h00;
    int         gap       = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("model", rpm_w_BCD, exp_out);
            check("tens_digit_valid", {7'd0, rpm_w_BCD[7:4] <= 4'd9}, 8'd1);
            check("units_digit_valid", {7'd0, rpm_w_BCD[3:0] <= 4'd9}, 8'd1);
            gap++;
            if (!rst_n) begin
                have_prev = 1'b0;
            end else if (rpm_w_BCD !== prev_out) begin
                if (have_prev) check("update_spacing", {7'd0, gap >= 9}, 8'd1);
                have_prev = 1'b1;
                gap       = 0;
            end
            prev_out = rpm_w_BCD;
        end
    end

    task automatic hold(input int v, input int n);
        rpm = 7'(v);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rpm   = 7'd0;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_value", rpm_w_BCD, 8'h00);
        rst_n = 1'b1;

        hold(22, 18);  check("basic_22", rpm_w_BCD, 8'h22);
        hold(95, 18);  check("step_95", rpm_w_BCD, 8'h95);
        hold(100, 18); check("sat_100", rpm_w_BCD, 8'h99);
        hold(127, 18); check("sat_127", rpm_w_BCD, 8'h99);
        hold(99, 18);  check("max_99", rpm_w_BCD, 8'h99);
        hold(0, 18);   check("zero", rpm_w_BCD, 8'h00);
        hold(9, 18);   check("nine", rpm_w_BCD, 8'h09);
        hold(10, 18);  check("ten", rpm_w_BCD, 8'h10);

        // Asynchronous clear mid-frame, then the first result one frame after release.
        hold(22, 18);
        check("pre_reset_22", rpm_w_BCD, 8'h22);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_clear", rpm_w_BCD, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_hold", rpm_w_BCD, 8'h00);
        @(negedge clk);
        check("first_write", rpm_w_BCD, 8'h22);

        for (int v = 0; v < 100; v++) begin
            hold(v, 18);
            check("sweep", rpm_w_BCD, {4'(v / 10), 4'(v % 10)});
        end

        // rpm toggling faster than a frame must only ever show one of the two values.
        hold(3, 18);
        for (int i = 0; i < 40; i++) begin
            rpm = (i % 2 == 0) ? 7'd47 : 7'd3;
            repeat (2) begin
                @(negedge clk);
                check("toggle_values", {7'd0, (rpm_w_BCD == 8'h03) || (rpm_w_BCD == 8'h47)}, 8'd1);
            end
        end

        for (int i = 0; i < 80; i++) begin
            hold(int'($urandom_range(0, 127)), int'($urandom_range(1, 20)));
        end
        hold(int'($urandom_range(0, 127)), 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
